// File: rtl/hazard_ctrl_pkg.sv
// Shared types and sizing helpers for the decode-stage interlock controller.
// Imported by the scoreboard and the top-level controller.
package hazard_ctrl_pkg;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } hc_state_e;

    localparam int REG_IDX_W = 5;

    // A pending/inflight counter must be able to hold the value MAX_INFLIGHT itself.
    function automatic int pend_w(input int max_inflight);
        return $clog2(max_inflight) + 1;
    endfunction

endpackage

// File: rtl/hazard_ctrl_scoreboard.sv
// Per-register pending-write counters with issue/retire/clear updates
// and the two source-operand busy lookups used for RAW detection.
module hc_scoreboard
    import hazard_ctrl_pkg::*;
#(
    parameter int NREG      = 32,
    parameter int PW        = 3,
    parameter int WB_BYPASS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 issue,
    input  logic [REG_IDX_W-1:0] issue_ind,
    input  logic                 retire,
    input  logic [REG_IDX_W-1:0] retire_ind,
    input  logic [REG_IDX_W-1:0] rs1_ind,
    input  logic [REG_IDX_W-1:0] rs2_ind,
    output logic                 rs1_busy,
    output logic                 rs2_busy,
    output logic                 underflow
);

    localparam logic BYPASS = (WB_BYPASS != 0) ? 1'b1 : 1'b0;

    logic [PW-1:0] pend_r [NREG];
    logic [PW-1:0] eff1_s;
    logic [PW-1:0] eff2_s;

    // Pending counters; x0 is pinned to zero and never tracked.
    always_ff @(posedge clk) begin
        pend_r[0] <= '0;
        for (int r = 1; r < NREG; r++) begin
            if (rst || clear) begin
                pend_r[r] <= '0;
            end else if ((issue && (issue_ind == REG_IDX_W'(r))) &&
                         !(retire && (retire_ind == REG_IDX_W'(r)))) begin
                pend_r[r] <= pend_r[r] + PW'(1);
            end else if ((retire && (retire_ind == REG_IDX_W'(r))) &&
                         !(issue && (issue_ind == REG_IDX_W'(r))) &&
                         (pend_r[r] != '0)) begin
                pend_r[r] <= pend_r[r] - PW'(1);
            end else begin
                pend_r[r] <= pend_r[r];
            end
        end
    end

    // Effective pending count: a same-cycle writeback is already visible when bypassed.
    always_comb begin
        eff1_s = pend_r[rs1_ind]
               - PW'(BYPASS & retire & (retire_ind == rs1_ind));
        eff2_s = pend_r[rs2_ind]
               - PW'(BYPASS & retire & (retire_ind == rs2_ind));
    end

    assign rs1_busy  = (rs1_ind != REG_IDX_W'(0)) && (eff1_s != '0);
    assign rs2_busy  = (rs2_ind != REG_IDX_W'(0)) && (eff2_s != '0);
    assign underflow = retire && (pend_r[retire_ind] == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage interlock: RAW/window-full stall generation, in-flight
// tracking, post-flush recovery sequencing and stall statistics.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int NREG         = 32,
    parameter int MAX_INFLIGHT = 4,
    parameter int FLUSH_CYC    = 2,
    parameter int WB_BYPASS    = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                dec_valid,
    input  logic [REG_IDX_W-1:0]                dec_rs1_ind,
    input  logic [REG_IDX_W-1:0]                dec_rs2_ind,
    input  logic                                dec_rs1_used,
    input  logic                                dec_rs2_used,
    input  logic [REG_IDX_W-1:0]                dec_rd_ind,
    input  logic                                dec_rd_we,
    input  logic                                wb_valid,
    input  logic [REG_IDX_W-1:0]                wb_rd_ind,
    input  logic                                flush,
    output logic                                dec_stall,
    output logic [pend_w(MAX_INFLIGHT)-1:0]     inflight,
    output logic [31:0]                         stall_cnt,
    output logic                                sb_err
);

    localparam int IFW = pend_w(MAX_INFLIGHT);
    localparam int TW  = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [TW-1:0]  TIMER_LOAD = TW'((FLUSH_CYC > 0) ? (FLUSH_CYC - 1) : 0);
    localparam logic [IFW-1:0] MAX_CNT    = IFW'(MAX_INFLIGHT);

    hc_state_e     state_r;
    hc_state_e     state_nxt_s;
    logic [TW-1:0] timer_r;
    logic [TW-1:0] timer_nxt_s;

    logic issue_s;
    logic retire_s;
    logic retire_ok_s;
    logic rs1_busy_s;
    logic rs2_busy_s;
    logic underflow_s;
    logic raw_s;
    logic full_s;
    logic stall_s;

    assign issue_s     = dec_valid && !stall_s && dec_rd_we && (dec_rd_ind != REG_IDX_W'(0));
    assign retire_s    = wb_valid && (wb_rd_ind != REG_IDX_W'(0));
    // A retire against an idle register carries no real instruction, so inflight ignores it.
    assign retire_ok_s = retire_s && !underflow_s;

    hc_scoreboard #(
        .NREG      (NREG),
        .PW        (IFW),
        .WB_BYPASS (WB_BYPASS)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .clear      (flush),
        .issue      (issue_s),
        .issue_ind  (dec_rd_ind),
        .retire     (retire_s && !flush),
        .retire_ind (wb_rd_ind),
        .rs1_ind    (dec_rs1_ind),
        .rs2_ind    (dec_rs2_ind),
        .rs1_busy   (rs1_busy_s),
        .rs2_busy   (rs2_busy_s),
        .underflow  (underflow_s)
    );

    assign raw_s  = (dec_rs1_used && rs1_busy_s) || (dec_rs2_used && rs2_busy_s);
    assign full_s = (inflight == MAX_CNT) && !retire_s;

    // Decode stall: zero in reset, forced through the flush cycle and FLUSH, else hazard-driven.
    always_comb begin
        stall_s = 1'b0;
        if (rst) begin
            stall_s = 1'b0;
        end else if (flush || (state_r == FLUSH)) begin
            stall_s = 1'b1;
        end else begin
            stall_s = dec_valid && (raw_s || full_s);
        end
    end

    assign dec_stall = stall_s;

    // Flush recovery next-state and timer.
    always_comb begin
        state_nxt_s = state_r;
        timer_nxt_s = timer_r;
        case (state_r)
            RUN: begin
                if (flush && (FLUSH_CYC > 0)) begin
                    state_nxt_s = FLUSH;
                    timer_nxt_s = TIMER_LOAD;
                end else begin
                    state_nxt_s = RUN;
                    timer_nxt_s = TW'(0);
                end
            end
            FLUSH: begin
                if (flush) begin
                    state_nxt_s = FLUSH;
                    timer_nxt_s = TIMER_LOAD;
                end else if (timer_r == TW'(0)) begin
                    state_nxt_s = RUN;
                    timer_nxt_s = TW'(0);
                end else begin
                    state_nxt_s = FLUSH;
                    timer_nxt_s = timer_r - TW'(1);
                end
            end
            default: begin
                state_nxt_s = RUN;
                timer_nxt_s = TW'(0);
            end
        endcase
    end

    // FSM state and timer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= RUN;
            timer_r <= TW'(0);
        end else begin
            state_r <= state_nxt_s;
            timer_r <= timer_nxt_s;
        end
    end

    // Outstanding register-write count; cleared at the flush edge.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            inflight <= IFW'(0);
        end else if (issue_s && !retire_ok_s) begin
            inflight <= inflight + IFW'(1);
        end else if (retire_ok_s && !issue_s && (inflight != IFW'(0))) begin
            inflight <= inflight - IFW'(1);
        end else begin
            inflight <= inflight;
        end
    end

    // Saturating stalled-cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 32'd0;
        end else if (dec_valid && stall_s && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end else begin
            stall_cnt <= stall_cnt;
        end
    end

    // Sticky scoreboard underflow flag; a flush-cycle retire is discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            sb_err <= 1'b0;
        end else if (underflow_s && !flush) begin
            sb_err <= 1'b1;
        end else begin
            sb_err <= sb_err;
        end
    end

endmodule
